uart_cmd_decoder: RTL

Framed command decoder between the UART receiver and the waveform generator. It collects 3-byte command frames from the UART receive byte stream and verifies each frame's checksum. On a good frame it updates the registered waveform, frequency and amplitude selects. It then requests a one-byte ACK/NAK reply through the UART transmitter. Malformed or stalled frames never disturb the select outputs, so the DAC path only ever sees complete, validated configurations.

---
 rtl/uart_cmd_decoder_if.sv | 55 +++++
 rtl/uart_cmd_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_decoder_if
// Purpose  : Bundles the UART byte handshake and the decoded configuration
//            outputs of the command decoder into one connection.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_cmd_decoder_if;

  // Receive side: one-cycle strobe plus the byte it qualifies
  logic       rx_valid;
  logic [7:0] rx_data;

  // Transmit side: reply request towards the UART transmitter
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  // Decoded configuration towards the waveform generator
  logic [2:0] wave_sel;
  logic [2:0] freq_sel;
  logic [1:0] amp_sel;
  logic       cfg_update;
  logic [7:0] err_cnt;

  // Environment side (UART and waveform generator / testbench)
  modport master (
    output rx_valid,
    output rx_data,
    output tx_busy,
    input  tx_start,
    input  tx_data,
    input  wave_sel,
    input  freq_sel,
    input  amp_sel,
    input  cfg_update,
    input  err_cnt
  );

  // Decoder side
  modport slave (
    input  rx_valid,
    input  rx_data,
    input  tx_busy,
    output tx_start,
    output tx_data,
    output wave_sel,
    output freq_sel,
    output amp_sel,
    output cfg_update,
    output err_cnt
  );

endinterface
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_decoder
// Purpose  : Collects 3-byte command frames (header, command, inverted
//            command) from the UART receive stream, applies validated
//            commands to the waveform/frequency/amplitude selects and asks
//            the UART transmitter to return a one-byte ACK or NAK.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYC = 5_000_000,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter logic [7:0]  ACK_BYTE    = 8'h06,
  parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
  input  wire logic          clk,
  input  wire logic          rst,
  uart_cmd_decoder_if.slave  bus
);

  // Inter-byte counter only ever needs to reach TIMEOUT_CYC-1
  localparam int unsigned      CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_GET_CMD    = 2'd1,
    ST_GET_CHK    = 2'd2,
    ST_SEND_REPLY = 2'd3
  } state_t;

  // Registered state and its next values
  state_t           state,      state_nxt;
  logic [7:0]       cmd,        cmd_nxt;
  logic [CNT_W-1:0] cnt,        cnt_nxt;
  logic [2:0]       wave_q,     wave_nxt;
  logic [2:0]       freq_q,     freq_nxt;
  logic [1:0]       amp_q,      amp_nxt;
  logic             cfg_q,      cfg_nxt;
  logic             txs_q,      txs_nxt;
  logic [7:0]       txd_q,      txd_nxt;
  logic [7:0]       err_q,      err_nxt;

  // Helper terms
  logic [7:0]       cmd_inv;
  logic             chk_ok;
  logic             tmo_hit;
  logic             hdr_seen;
  logic [7:0]       err_inc;

  assign cmd_inv  = ~cmd;
  assign chk_ok   = (bus.rx_data == cmd_inv);
  assign tmo_hit  = (cnt == CNT_LAST);
  assign hdr_seen = bus.rx_valid && (bus.rx_data == HDR_BYTE);
  // Rejected-frame counter sticks at its maximum instead of wrapping
  assign err_inc  = (err_q == 8'hFF) ? 8'hFF : (err_q + 8'd1);

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cmd    <= 8'h00;
      cnt    <= '0;
      wave_q <= 3'd0;
      freq_q <= 3'd0;
      amp_q  <= 2'd0;
      cfg_q  <= 1'b0;
      txs_q  <= 1'b0;
      txd_q  <= 8'h00;
      err_q  <= 8'h00;
    end else begin
      state  <= state_nxt;
      cmd    <= cmd_nxt;
      cnt    <= cnt_nxt;
      wave_q <= wave_nxt;
      freq_q <= freq_nxt;
      amp_q  <= amp_nxt;
      cfg_q  <= cfg_nxt;
      txs_q  <= txs_nxt;
      txd_q  <= txd_nxt;
      err_q  <= err_nxt;
    end
  end

  // Next-state and next-output decode for the frame collector
  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd;
    cnt_nxt   = cnt;
    wave_nxt  = wave_q;
    freq_nxt  = freq_q;
    amp_nxt   = amp_q;
    cfg_nxt   = 1'b0;
    txs_nxt   = 1'b0;
    txd_nxt   = txd_q;
    err_nxt   = err_q;

    case (state)
      ST_IDLE: begin
        // Non-header bytes are line noise and are dropped without counting
        cnt_nxt = '0;
        if (hdr_seen) begin
          state_nxt = ST_GET_CMD;
        end
      end

      ST_GET_CMD: begin
        // Any byte is a legal command, including one equal to the header;
        // a byte in the timeout cycle takes priority over the timeout
        if (bus.rx_valid) begin
          cmd_nxt   = bus.rx_data;
          cnt_nxt   = '0;
          state_nxt = ST_GET_CHK;
        end else if (tmo_hit) begin
          cmd_nxt   = 8'h00;
          cnt_nxt   = '0;
          err_nxt   = err_inc;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_GET_CHK: begin
        if (bus.rx_valid) begin
          cnt_nxt = '0;
          if (chk_ok) begin
            {wave_nxt, freq_nxt, amp_nxt} = cmd;
            cfg_nxt = 1'b1;
            txd_nxt = ACK_BYTE;
          end else begin
            txd_nxt = NAK_BYTE;
            err_nxt = err_inc;
          end
          // Reply can go out together with the new selects if the
          // transmitter is already free
          txs_nxt   = !bus.tx_busy;
          state_nxt = ST_SEND_REPLY;
        end else if (tmo_hit) begin
          cmd_nxt   = 8'h00;
          cnt_nxt   = '0;
          err_nxt   = err_inc;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_SEND_REPLY: begin
        // Received bytes are ignored here. The state is left one cycle after
        // the tx_start pulse, so a new header is accepted from then on.
        cnt_nxt = '0;
        if (txs_q) begin
          state_nxt = ST_IDLE;
        end else if (!bus.tx_busy) begin
          txs_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.wave_sel   = wave_q;
  assign bus.freq_sel   = freq_q;
  assign bus.amp_sel    = amp_q;
  assign bus.cfg_update = cfg_q;
  assign bus.tx_start   = txs_q;
  assign bus.tx_data    = txd_q;
  assign bus.err_cnt    = err_q;

endmodule
`default_nettype wire
